// File: rtl/vec_reg_bank.sv
// vec_reg_bank: DEPTH x BITS register bank with one synchronous write port
// and a burst read engine that streams a contiguous, wrap-around run of
// entries over a valid/ready handshake. The registered output element can
// also be driven onto a shared tristate result bus.
module vec_reg_bank #(
  parameter int BITS  = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic            burst_start,
  input  logic [AW-1:0]   burst_addr,
  input  logic [AW:0]     burst_len,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_last,
  input  logic            oe,
  output logic [BITS-1:0] bus_out
);

  typedef enum logic {IDLE, STREAM} state_e;

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   ONE_W    = (AW+1)'(1);

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     rem_q, rem_d;
  logic [BITS-1:0] data_q, data_d;
  logic [BITS-1:0] mem_q [DEPTH];

  logic            wr_ok;
  logic [AW-1:0]   start_addr;
  logic [AW:0]     len_clamped;
  logic [AW-1:0]   next_ptr;
  logic            handshake;
  logic            load_en;
  logic [AW-1:0]   load_addr;
  logic [BITS-1:0] load_data;

  // Out-of-range write addresses are dropped; out-of-range burst addresses
  // restart at entry 0 and over-long bursts are clamped to one full pass.
  assign wr_ok       = wr_en && ({1'b0, wr_addr} < DEPTH_W);
  assign start_addr  = ({1'b0, burst_addr} < DEPTH_W) ? burst_addr : '0;
  assign len_clamped = (burst_len > DEPTH_W) ? DEPTH_W : burst_len;
  assign next_ptr    = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
  assign handshake   = (state_q == STREAM) && out_ready;

  // Next-state logic for the burst engine plus selection of the word that
  // gets loaded into the output register, with same-cycle write bypass.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    load_en   = 1'b0;
    load_addr = ptr_q;
    case (state_q)
      IDLE: begin
        if (burst_start && (burst_len != '0)) begin
          state_d   = STREAM;
          ptr_d     = start_addr;
          rem_d     = len_clamped;
          load_en   = 1'b1;
          load_addr = start_addr;
        end
      end
      STREAM: begin
        if (handshake) begin
          if (rem_q > ONE_W) begin
            ptr_d     = next_ptr;
            rem_d     = rem_q - 1'b1;
            load_en   = 1'b1;
            load_addr = next_ptr;
          end else begin
            state_d = IDLE;
            rem_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    load_data = (wr_ok && (wr_addr == load_addr)) ? wr_data : mem_q[load_addr];
    data_d    = load_en ? load_data : data_q;
  end

  // Storage array: cleared on reset, written whenever the address is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Burst engine state and the registered output element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  assign busy      = (state_q == STREAM);
  assign out_valid = (state_q == STREAM);
  assign out_last  = (state_q == STREAM) && (rem_q == ONE_W);
  assign out_data  = data_q;
  assign bus_out   = (oe && out_valid) ? data_q : {BITS{1'bz}};

endmodule

// File: tb/tb_vec_reg_bank.sv
// tb_vec_reg_bank: directed self-checking bench for vec_reg_bank (BITS=8,
// DEPTH=8). Inputs change and outputs are checked on the falling clock edge.
module tb_vec_reg_bank;

  logic       clk;
  logic       rstN;
  logic       wrEn;
  logic [2:0] wrAddr;
  logic [7:0] wrData;
  logic       burstStart;
  logic [2:0] burstAddr;
  logic [3:0] burstLen;
  logic       busy;
  logic       outValid;
  logic       outReady;
  logic [7:0] outData;
  logic       outLast;
  logic       oe;
  logic [7:0] busOut;

  int nTests  = 0;
  int nFailed = 0;

  logic [31:0] zBus;

  vec_reg_bank #(.BITS(8), .DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .wr_en      (wrEn),
    .wr_addr    (wrAddr),
    .wr_data    (wrData),
    .burst_start(burstStart),
    .burst_addr (burstAddr),
    .burst_len  (burstLen),
    .busy       (busy),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_data   (outData),
    .out_last   (outLast),
    .oe         (oe),
    .bus_out    (busOut)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value (4-state exact).
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Check valid/data/last of the element currently presented.
  task automatic checkElem(input string tag, input logic expValid,
                           input logic [7:0] expData, input logic expLast);
    checkOutput({tag, ".valid"}, {31'h0, outValid}, {31'h0, expValid});
    if (expValid) begin
      checkOutput({tag, ".data"}, {24'h0, outData}, {24'h0, expData});
      checkOutput({tag, ".last"}, {31'h0, outLast}, {31'h0, expLast});
    end
  endtask

  // Drive one cycle of inputs, let a rising edge pass, return at the next
  // falling edge so outputs can be checked.
  task automatic applyStimulus(input logic we, input logic [2:0] wa,
                               input logic [7:0] wd, input logic bs,
                               input logic [2:0] ba, input logic [3:0] bl,
                               input logic rdy);
    wrEn       = we;
    wrAddr     = wa;
    wrData     = wd;
    burstStart = bs;
    burstAddr  = ba;
    burstLen   = bl;
    outReady   = rdy;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp8;
    zBus = {24'h0, 8'hzz};
    rstN = 1'b0;
    oe   = 1'b1;
    wrEn = 1'b0; wrAddr = '0; wrData = '0;
    burstStart = 1'b0; burstAddr = '0; burstLen = '0; outReady = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst.busy",  {31'h0, busy},     32'h0);
    checkOutput("rst.valid", {31'h0, outValid}, 32'h0);
    checkOutput("rst.data",  {24'h0, outData},  32'h0);
    checkOutput("rst.bus",   {24'h0, busOut},   zBus);
    rstN = 1'b1;
    @(negedge clk);

    // Load mem[i] = 0x10 + i
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 3'(i), 8'(8'h10 + i), 1'b0, 3'd0, 4'd0, 1'b1);

    // Basic burst: addr 2, len 3
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 4'd3, 1'b1);
    checkElem("basic0", 1'b1, 8'h12, 1'b0);
    checkOutput("basic0.bus", {24'h0, busOut}, 32'h12);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 1'b1);
    checkElem("basic1", 1'b1, 8'h13, 1'b0);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 1'b1);
    checkElem("basic2", 1'b1, 8'h14, 1'b1);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 1'b1);
    checkElem("basicEnd", 1'b0, 8'h00, 1'b0);
    checkOutput("basicEnd.busy", {31'h0, busy}, 32'h0);

    // Wrap and clamp: addr 6, len 12 -> 8 elements; starts while busy ignored
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 4'd12, 1'b1);
    for (int k = 0; k < 8; k++) begin
      exp8 = 8'(8'h10 + ((6 + k) % 8));
      checkElem($sformatf("wrap%0d", k), 1'b1, exp8, (k == 7));
      applyStimulus(1'b0, 3'd0, 8'h00, (k == 3 || k == 7), 3'd0, 4'd2, 1'b1);
    end
    checkElem("wrapEnd", 1'b0, 8'h00, 1'b0);

    // Backpressure: len 4 from 0, stall 3 cycles on element 1, and write
    // 0xBB to the presented address during the stall (snapshot holds)
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 4'd4, 1'b1);
    checkElem("bp0", 1'b1, 8'h10, 1'b0);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 1'b1);
    checkElem("bp1", 1'b1, 8'h11, 1'b0);
    for (int s = 0; s < 3; s++) begin
      applyStimulus((s == 1), 3'd1, 8'hBB, 1'b0, 3'd0, 4'd0, 1'b0);
      checkElem($sformatf("bpHold%0d", s), 1'b1, 8'h11, 1'b0);
    end
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 1'b1);
    checkElem("bp2", 1'b1, 8'h12, 1'b0);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 1'b1);
    checkElem("bp3", 1'b1, 8'h13, 1'b1);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 1'b1);
    checkElem("bpEnd", 1'b0, 8'h00, 1'b0);

    // Bypass: write 0xAA to entry 5 on the edge that loads it
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 4'd3, 1'b1);
    checkElem("byp0", 1'b1, 8'h14, 1'b0);
    applyStimulus(1'b1, 3'd5, 8'hAA, 1'b0, 3'd0, 4'd0, 1'b1);
    checkElem("byp1", 1'b1, 8'hAA, 1'b0);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 1'b1);
    checkElem("byp2", 1'b1, 8'h16, 1'b1);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 1'b1);
    checkElem("bypEnd", 1'b0, 8'h00, 1'b0);

    // Zero-length request is ignored
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 4'd0, 1'b1);
    checkOutput("len0.busy", {31'h0, busy}, 32'h0);
    checkOutput("len0.bus",  {24'h0, busOut}, zBus);

    // oe=0 floats the bus while the element is valid; mem[1] now holds 0xBB
    oe = 1'b0;
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 4'd2, 1'b0);
    checkElem("oe0", 1'b1, 8'h10, 1'b0);
    checkOutput("oe0.bus", {24'h0, busOut}, zBus);
    oe = 1'b1;
    #1;
    checkOutput("oe1.bus", {24'h0, busOut}, 32'h10);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 1'b1);
    checkElem("oe1", 1'b1, 8'hBB, 1'b1);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 1'b1);
    checkElem("oeEnd", 1'b0, 8'h00, 1'b0);

    // Reset mid-stream aborts immediately and clears storage
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 4'd5, 1'b1);
    checkElem("mid0", 1'b1, 8'h12, 1'b0);
    rstN = 1'b0;
    #1;
    checkOutput("midRst.busy",  {31'h0, busy},     32'h0);
    checkOutput("midRst.valid", {31'h0, outValid}, 32'h0);
    checkOutput("midRst.data",  {24'h0, outData},  32'h0);
    checkOutput("midRst.bus",   {24'h0, busOut},   zBus);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 1'b1);
    checkOutput("postRst.busy", {31'h0, busy}, 32'h0);

    // Full burst of 8 from 0 after reset returns zeros
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 4'd8, 1'b1);
    for (int k = 0; k < 8; k++) begin
      checkElem($sformatf("zero%0d", k), 1'b1, 8'h00, (k == 7));
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 4'd0, 1'b1);
    end
    checkElem("zeroEnd", 1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFailed);
    $finish;
  end

endmodule
